// File: rtl/led_seq_checker.sv
// Checks that a strobed LED bus follows the wrap-around count, acquiring lock and tracking mismatches.
// All outputs registered one cycle after the strobe; there is no backpressure, only sample_strb qualifies input.
module led_seq_checker #(
  parameter int DATA_W     = 4,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic              clk_50Mhz,
  input  logic              res,
  input  logic [DATA_W-1:0] led_in,
  input  logic              sample_strb,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  good_count,
  output logic [DATA_W-1:0] last_val,
  output logic [1:0]        state
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e            state_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] exp_q;
  logic [RUN_W-1:0]  run_q;
  logic [MISS_W-1:0] miss_q;

  logic match;
  logic bad_hit;
  logic good_hit;

  assign match    = (led_in == exp_q);
  assign bad_hit  = sample_strb && (state_q == ST_LOCKED) && !match;
  assign good_hit = sample_strb && (state_q == ST_LOCKED) && match;

  // Clear is applied first so a coincident counting event leaves the counter at one.
  always_comb begin
    err_cnt_d  = clr_cnt ? '0 : err_cnt_q;
    good_cnt_d = clr_cnt ? '0 : good_cnt_q;
    if (bad_hit && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + CNT_ONE;
    end
    if (good_hit && (good_cnt_d != '1)) begin
      good_cnt_d = good_cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk_50Mhz or posedge res) begin
    if (res) begin
      state_q     <= ST_SEARCH;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      last_q      <= '0;
      exp_q       <= '0;
      run_q       <= '0;
      miss_q      <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      if (sample_strb) begin
        last_q <= led_in;
        exp_q  <= led_in + DATA_ONE;
      end
      case (state_q)
        ST_SEARCH: begin
          if (sample_strb) begin
            run_q   <= RUN_ONE;
            state_q <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (sample_strb) begin
            if (!match) begin
              run_q <= RUN_ONE;
            end else if (run_q == RUN_LOCK) begin
              // run_q counts the reference plus prior matches, so this is match number LOCK_CNT.
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              miss_q   <= '0;
            end else begin
              run_q <= run_q + RUN_ONE;
            end
          end
        end
        ST_LOCKED: begin
          if (sample_strb) begin
            if (match) begin
              miss_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (miss_q == MISS_LAST) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + MISS_ONE;
              end
            end
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
          run_q    <= '0;
          miss_q   <= '0;
        end
      endcase
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;
  assign good_count = good_cnt_q;
  assign last_val   = last_q;
  assign state      = state_q;

endmodule
